// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port plus the fetch->decode handoff
// signals of the fetch stage.
// master = fetch side, slave = memory/decode side.
interface fetch_unit_if #(
    parameter int unsigned WORD_SIZE = 16
) ();

    // Instruction memory read port
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [WORD_SIZE-1:0] i_data;
    logic                 i_ready;

    // Fetch -> decode handoff
    logic                 id_ready;
    logic                 if_valid;
    logic [WORD_SIZE-1:0] if_inst;
    logic [WORD_SIZE-1:0] if_pc;

    modport master (
        output i_readM,
        output i_address,
        input  i_data,
        input  i_ready,
        input  id_ready,
        output if_valid,
        output if_inst,
        output if_pc
    );

    modport slave (
        input  i_readM,
        input  i_address,
        output i_data,
        output i_ready,
        output id_ready,
        input  if_valid,
        input  if_inst,
        input  if_pc
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// - Issues one memory read at a time.
// - Hands instructions to decode through a single output slot.
// - Parks a response in a one-entry hold register while decode stalls.
// - Drops stale responses after a redirect.
// - Stops permanently on halt.
// Optional feature: define FETCH_CNT_EN to add the num_inst port, which counts
// handed-off instructions.
module fetch_unit #(
    parameter int unsigned          WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fetch_unit_if.master         bus,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 is_halted
`ifdef FETCH_CNT_EN
    ,
    output logic [WORD_SIZE-1:0] num_inst
`endif
);

    localparam int unsigned  W   = WORD_SIZE;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e       state_q,     state_d;
    logic [W-1:0] pc_q,        pc_d;
    logic [W-1:0] req_addr_q,  req_addr_d;
    logic [W-1:0] hold_q,      hold_d;
    logic [W-1:0] if_inst_q,   if_inst_d;
    logic [W-1:0] if_pc_q,     if_pc_d;
    logic         if_valid_q,  if_valid_d;
    logic         halted_q,    halted_d;
    logic         readm_q,     readm_d;
    logic         is_halted_q, is_halted_d;

    logic         handoff;
    logic         slot_free;
    logic [W-1:0] pc_inc;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        hold_d      = hold_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        halted_d    = halted_q;
        readm_d     = 1'b0;
        is_halted_d = 1'b0;

        pc_inc    = pc_q + ONE;
        handoff   = if_valid_q & bus.id_ready;
        slot_free = ~if_valid_q | handoff;

        // A consumed instruction empties the slot unless something refills it below
        if (handoff) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (halt) begin
                    // Halt wins over redirect; an in-flight read must still be drained
                    halted_d   = 1'b1;
                    if_valid_d = 1'b0;
                    state_d    = bus.i_ready ? S_HALT : S_DROP;
                end else if (redirect) begin
                    if_valid_d = 1'b0;
                    hold_d     = '0;
                    pc_d       = redirect_pc;
                    if (bus.i_ready) begin
                        // Response belongs to the old path: discard and reissue
                        req_addr_d = redirect_pc;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (bus.i_ready) begin
                    pc_d = pc_inc;
                    if (slot_free) begin
                        if_inst_d  = bus.i_data;
                        if_pc_d    = pc_inc;
                        if_valid_d = 1'b1;
                        req_addr_d = pc_inc;
                    end else begin
                        hold_d  = bus.i_data;
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (halt) begin
                    halted_d   = 1'b1;
                    if_valid_d = 1'b0;
                    state_d    = S_HALT;
                end else if (redirect) begin
                    if_valid_d = 1'b0;
                    hold_d     = '0;
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (slot_free) begin
                    // pc already points past the held instruction
                    if_inst_d  = hold_q;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end
            end

            S_DROP: begin
                if (halt) begin
                    halted_d   = 1'b1;
                    if_valid_d = 1'b0;
                end else if (redirect && !halted_q) begin
                    // Latest redirect target wins; the outstanding read is still drained
                    if_valid_d = 1'b0;
                    hold_d     = '0;
                    pc_d       = redirect_pc;
                end
                if (bus.i_ready) begin
                    if (halted_d) begin
                        state_d = S_HALT;
                    end else begin
                        req_addr_d = pc_d;
                        state_d    = S_REQ;
                    end
                end
            end

            S_HALT: begin
                if_valid_d = 1'b0;
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        readm_d     = (state_d == S_REQ) || (state_d == S_DROP);
        is_halted_d = (state_d == S_HALT);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            hold_q      <= '0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            if_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            readm_q     <= 1'b1;
            is_halted_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            hold_q      <= hold_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            if_valid_q  <= if_valid_d;
            halted_q    <= halted_d;
            readm_q     <= readm_d;
            is_halted_q <= is_halted_d;
        end
    end

    assign bus.i_readM   = readm_q;
    assign bus.i_address = req_addr_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.if_pc     = if_pc_q;
    assign is_halted     = is_halted_q;

`ifdef FETCH_CNT_EN
    logic [W-1:0] cnt_q, cnt_d;

    // Handed-off instruction count, independent of redirect/halt
    always_comb begin
        cnt_d = cnt_q;
        if (handoff) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign num_inst = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit.
// Contents:
// - a latency-configurable memory responder;
// - directed sequences;
// - a redirect-target vector table;
// - randomized episodes checked against a program-order model of the handed-off
//   instruction stream.
// The num_inst checks are compiled in when FETCH_CNT_EN is defined.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    logic         halt;
    logic         is_halted;
`ifdef FETCH_CNT_EN
    logic [W-1:0] num_inst;
`endif

    fetch_unit_if #(.WORD_SIZE(W)) bus ();

    fetch_unit #(
        .WORD_SIZE (W),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .is_halted   (is_halted)
`ifdef FETCH_CNT_EN
        ,
        .num_inst    (num_inst)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory responder state
    bit           busy;
    bit           delayed;
    int           wait_cnt;
    int           mem_lat;
    bit           mem_rand;
    logic [W-1:0] req_a;

    typedef struct {
        logic [15:0] redir_pc;
        int          lat;
        logic [15:0] exp_inst;
        logic [15:0] exp_pc;
        logic [15:0] exp_next;
    } vec_t;

    vec_t vecs[6];

    // Random-episode model state
    logic [W-1:0] exp_pc;
    int           nho;
    int           cnt;
    bit           mh;
    int           halt_at;
    int           hcnt;
    int           n;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h6001;
        if (a == 16'h0001) return 16'hF01C;
        return a ^ 16'hA5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One memory request at a time; the response pulses after the chosen latency
    task automatic mem_step();
        bus.i_ready = 1'b0;
        if (!reset_n) begin
            busy = 1'b0;
            return;
        end
        if (bus.i_readM && !busy) begin
            busy     = 1'b1;
            delayed  = 1'b0;
            req_a    = bus.i_address;
            wait_cnt = mem_rand ? int'($urandom_range(0, 2)) : mem_lat;
        end
        if (busy) begin
            if (wait_cnt == 0) begin
                if (delayed)
                    check("addr_stable", 32'({bus.i_readM, bus.i_address}), 32'({1'b1, req_a}));
                bus.i_ready = 1'b1;
                bus.i_data  = mem_word(req_a);
                busy        = 1'b0;
            end else begin
                wait_cnt--;
                delayed = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int k = 0;
        while (!bus.if_valid && k < limit) begin
            tick();
            k++;
        end
        check(name, 32'(bus.if_valid), 32'd1);
    endtask

    task automatic wait_addr(input string name, input logic [15:0] a, input int limit);
        int k = 0;
        while (bus.i_address !== a && k < limit) begin
            tick();
            k++;
        end
        check(name, 32'(bus.i_address), 32'(a));
    endtask

    task automatic wait_readm_low(input string name, input int limit);
        int k = 0;
        while (bus.i_readM && k < limit) begin
            tick();
            k++;
        end
        check(name, 32'(bus.i_readM), 32'd0);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h0040, 2, 16'hA5E5, 16'h0041, 16'h0041};
        vecs[1] = '{16'hFFFF, 1, 16'h5A5A, 16'h0000, 16'h0000};
        vecs[2] = '{16'h1234, 0, 16'hB791, 16'h1235, 16'h1235};
        vecs[3] = '{16'h7FFF, 3, 16'hDA5A, 16'h8000, 16'h8000};
        vecs[4] = '{16'h0001, 1, 16'hF01C, 16'h0002, 16'h0002};
        vecs[5] = '{16'hFFFE, 2, 16'h5A5B, 16'hFFFF, 16'hFFFF};

        reset_n      = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        halt         = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_data   = '0;
        bus.id_ready = 1'b1;
        busy         = 1'b0;
        delayed      = 1'b0;
        wait_cnt     = 0;
        mem_rand     = 1'b0;
        mem_lat      = 2;

        // Reset state, first fetch, then hold while decode stalls
        tick();
        tick();
        check("rst_if_valid",  32'(bus.if_valid),  32'd0);
        check("rst_if_inst",   32'(bus.if_inst),   32'd0);
        check("rst_if_pc",     32'(bus.if_pc),     32'd0);
        check("rst_is_halted", 32'(is_halted),     32'd0);
        check("rst_readm",     32'(bus.i_readM),   32'd1);
        check("rst_addr",      32'(bus.i_address), 32'h0000);
`ifdef FETCH_CNT_EN
        check("rst_num_inst",  32'(num_inst),      32'd0);
`endif
        reset_n = 1'b1;
        tick();
        check("first_readm", 32'(bus.i_readM),   32'd1);
        check("first_addr",  32'(bus.i_address), 32'h0000);
        wait_valid("v0_valid", 10);
        check("v0_inst", 32'(bus.if_inst),   32'h6001);
        check("v0_pc",   32'(bus.if_pc),     32'h0001);
        check("v0_next", 32'(bus.i_address), 32'h0001);
        bus.id_ready = 1'b0;
        wait_readm_low("hold_enter", 10);
        check("hold_keep_inst",  32'(bus.if_inst),  32'h6001);
        check("hold_keep_valid", 32'(bus.if_valid), 32'd1);
        tick();
        tick();
        check("hold_readm", 32'(bus.i_readM), 32'd0);
        bus.id_ready = 1'b1;
        tick();
        check("hold_inst",  32'(bus.if_inst),   32'hF01C);
        check("hold_pc",    32'(bus.if_pc),     32'h0002);
        check("hold_valid", 32'(bus.if_valid),  32'd1);
        check("hold_readm_back", 32'(bus.i_readM), 32'd1);
        check("hold_addr",  32'(bus.i_address), 32'h0002);

        // Redirect while a read is outstanding
        mem_lat = 4;
        do_reset();
        bus.id_ready = 1'b1;
        wait_addr("reach3", 16'h0003, 60);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("drop_valid", 32'(bus.if_valid),  32'd0);
        check("drop_addr",  32'(bus.i_address), 32'h0003);
        check("drop_readm", 32'(bus.i_readM),   32'd1);
        n = 0;
        while (bus.i_address === 16'h0003 && n < 20) begin
            check("drop_wait_valid", 32'(bus.if_valid), 32'd0);
            tick();
            n++;
        end
        check("redir_addr",  32'(bus.i_address), 32'h0040);
        check("redir_readm", 32'(bus.i_readM),   32'd1);
        wait_valid("redir_valid", 20);
        check("redir_inst", 32'(bus.if_inst), 32'hA5E5);
        check("redir_pc",   32'(bus.if_pc),   32'h0041);

        // Halt together with redirect, nothing outstanding
        mem_lat = 1;
        do_reset();
        bus.id_ready = 1'b1;
        wait_valid("h_valid", 20);
        bus.id_ready = 1'b0;
        wait_readm_low("h_hold", 20);
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        halt     = 1'b0;
        redirect = 1'b0;
        check("halt_is_halted", 32'(is_halted),    32'd1);
        check("halt_readm",     32'(bus.i_readM),  32'd0);
        check("halt_valid",     32'(bus.if_valid), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect     = 1'b0;
        bus.id_ready = 1'b1;
        repeat (5) tick();
        check("halt_stay",       32'(is_halted),    32'd1);
        check("halt_stay_readm", 32'(bus.i_readM),  32'd0);
        check("halt_stay_valid", 32'(bus.if_valid), 32'd0);

        // Reset in the middle of a request, with i_ready in the reset cycle
        mem_lat = 3;
        do_reset();
        bus.id_ready = 1'b1;
        wait_addr("mid_reach2", 16'h0002, 40);
        reset_n     = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_data  = 16'hBEEF;
        tick();
        check("mid_rst_valid", 32'(bus.if_valid),  32'd0);
        check("mid_rst_inst",  32'(bus.if_inst),   32'd0);
        check("mid_rst_addr",  32'(bus.i_address), 32'h0000);
        check("mid_rst_readm", 32'(bus.i_readM),   32'd1);
        reset_n = 1'b1;
        tick();
        wait_valid("mid_valid", 20);
        check("mid_inst", 32'(bus.if_inst), 32'h6001);
        check("mid_pc",   32'(bus.if_pc),   32'h0001);

        // Redirect-target vector table
        for (int v = 0; v < 6; v++) begin
            mem_lat = vecs[v].lat;
            do_reset();
            bus.id_ready = 1'b1;
            redirect     = 1'b1;
            redirect_pc  = vecs[v].redir_pc;
            tick();
            redirect = 1'b0;
            wait_valid($sformatf("vec%0d_valid", v), 30);
            check($sformatf("vec%0d_inst", v), 32'(bus.if_inst),   32'(vecs[v].exp_inst));
            check($sformatf("vec%0d_pc", v),   32'(bus.if_pc),     32'(vecs[v].exp_pc));
            check($sformatf("vec%0d_next", v), 32'(bus.i_address), 32'(vecs[v].exp_next));
        end

`ifdef FETCH_CNT_EN
        // Counter: 5 handoffs, redirect, 2 handoffs, then reset
        mem_lat = 0;
        do_reset();
        bus.id_ready = 1'b1;
        hcnt = 0;
        n    = 0;
        while (hcnt < 5 && n < 100) begin
            if (bus.if_valid && bus.id_ready) hcnt++;
            tick();
            n++;
        end
        bus.id_ready = 1'b0;
        redirect     = 1'b1;
        redirect_pc  = 16'h0100;
        tick();
        redirect     = 1'b0;
        bus.id_ready = 1'b1;
        while (hcnt < 7 && n < 200) begin
            if (bus.if_valid && bus.id_ready) hcnt++;
            tick();
            n++;
        end
        bus.id_ready = 1'b0;
        tick();
        check("cnt_seven", 32'(num_inst), 32'd7);
        reset_n = 1'b0;
        tick();
        check("cnt_reset", 32'(num_inst), 32'd0);
        reset_n = 1'b1;
`endif

        // Randomized episodes against the program-order model
        mem_rand = 1'b1;
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            exp_pc  = 16'h0000;
            nho     = 0;
            cnt     = 0;
            mh      = 1'b0;
            halt_at = (ep % 2 == 1) ? int'($urandom_range(50, 300)) : -1;
            for (int cyc = 0; cyc < 400; cyc++) begin
                bus.id_ready = ($urandom_range(0, 3) != 0);
                redirect     = ($urandom_range(0, 24) == 0);
                redirect_pc  = ($urandom_range(0, 3) == 0) ?
                               16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
                halt         = (cyc == halt_at);
                if (mh)
                    check("rnd_halted_valid", 32'(bus.if_valid), 32'd0);
                if (bus.if_valid && bus.id_ready) begin
                    check("rnd_handoff", {bus.if_inst, bus.if_pc},
                          {mem_word(exp_pc), exp_pc + 16'd1});
                    exp_pc = exp_pc + 16'd1;
                    nho++;
                    cnt++;
                end
                if (halt)
                    mh = 1'b1;
                else if (redirect && !mh)
                    exp_pc = redirect_pc;
                tick();
            end
            redirect = 1'b0;
            halt     = 1'b0;
            check("rnd_is_halted", 32'(is_halted), 32'(mh));
            if (mh)
                check("rnd_halt_readm", 32'(bus.i_readM), 32'd0);
            check("rnd_progress", 32'(nho > 10), 32'd1);
`ifdef FETCH_CNT_EN
            check("rnd_num_inst", 32'(num_inst), 32'(16'(cnt)));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
